// File: rtl/rec_median_stream.sv
// rec_median_stream: recursive 1-D median over a WIN-tap window, line framed, edges replicated, tail flushed per line.
// Latency: one cycle from the accept that completes a window to out_valid; FLUSH emits one output per free output slot.
// Backpressure: in_ready follows output-register space (always 1 in IDLE, 0 in FLUSH); optional macro RMF_NONREC_EN adds port `recursive`.
module rec_median_stream #(
  parameter int DATA_W = 8,
  parameter int WIN    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RMF_NONREC_EN
  input  logic              recursive,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sol,
  input  logic              in_eol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sol,
  output logic              out_eol,
  output logic              sync_err,
  output logic              busy
);

  localparam int K  = (WIN - 1) / 2;
  localparam int N  = 2 * K + 1;
  localparam int CW = $clog2(K + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_c;          // outputs still owed for the current line
  logic              r_first;      // next produce is the first of the line
  logic [DATA_W-1:0] r_h [1:K];    // past outputs, r_h[1] newest
  logic [DATA_W-1:0] r_f [0:K-1];  // look-ahead inputs, r_f[0] is the window centre
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_sol;
  logic              r_out_eol;
  logic              r_sync_err;

  logic              w_out_space;
  logic              w_acc;
  logic              w_start;
  logic              w_err;
  logic              w_prod;
  logic              w_last;
  logic              w_fshift;
  logic [DATA_W-1:0] w_s;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_hin;
  logic [DATA_W-1:0] w_win [0:N-1];

  assign w_out_space = !r_out_valid || out_ready;
  assign in_ready    = (r_state == S_IDLE)  ? 1'b1 :
                       (r_state == S_FLUSH) ? 1'b0 : w_out_space;
  assign w_acc       = in_valid && in_ready;
  // Any accepted sol restarts the line; in FILL/RUN the owed tail is dropped.
  assign w_start     = w_acc && in_sol;
  assign w_err       = w_acc && (in_sol ? (r_state == S_FILL || r_state == S_RUN)
                                        : (r_state == S_IDLE));
  assign w_prod      = (r_state == S_RUN && w_acc && !in_sol) ||
                       (r_state == S_FLUSH && w_out_space);
  assign w_last      = (r_state == S_FLUSH) && (r_c == CW'(1));
  assign w_fshift    = w_prod || (r_state == S_FILL && w_acc && !in_sol);
  // During the tail the newest sample is replicated to pad the right edge.
  assign w_s         = (r_state == S_FLUSH) ? r_f[K-1] : in_data;

`ifdef RMF_NONREC_EN
  logic r_rec;

  // Filter mode is chosen per line at the sol accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rec <= 1'b1;
    end else if (w_start) begin
      r_rec <= recursive;
    end
  end

  assign w_hin = r_rec ? w_y : r_f[0];
`else
  assign w_hin = w_y;
`endif

  // Assemble the 2K+1 window: history, look-ahead and the incoming sample.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      w_win[i]     = r_h[i+1];
      w_win[K + i] = r_f[i];
    end
    w_win[N-1] = w_s;
  end

  // Rank selection: a value is the K-th order statistic when K lies in its tie span.
  always_comb begin : p_median
    int lt;
    int le;
    lt  = 0;
    le  = 0;
    w_y = w_win[0];
    for (int i = 0; i < N; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < N; j++) begin
        if (w_win[j] <  w_win[i]) lt = lt + 1;
        if (w_win[j] <= w_win[i]) le = le + 1;
      end
      if (lt <= K && le > K) w_y = w_win[i];
    end
  end

  // Line FSM with window storage and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sol   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_sync_err  <= 1'b0;
      for (int i = 1; i <= K; i++) r_h[i] <= '0;
      for (int i = 0; i < K; i++)  r_f[i] <= '0;
    end else begin
      r_sync_err <= w_err;

      if (w_prod) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_y;
        r_out_sol   <= r_first;
        r_out_eol   <= w_last;
        r_first     <= 1'b0;
        r_h[1]      <= w_hin;
        for (int i = 2; i <= K; i++) r_h[i] <= r_h[i-1];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_start) begin
        // Left edge: history and look-ahead all replicate the first sample.
        for (int i = 1; i <= K; i++) r_h[i] <= in_data;
        for (int i = 0; i < K; i++)  r_f[i] <= in_data;
        r_c     <= CW'(1);
        r_first <= 1'b1;
        if (in_eol)     r_state <= S_FLUSH;
        else if (K > 1) r_state <= S_FILL;
        else            r_state <= S_RUN;
      end else if (w_fshift) begin
        for (int i = 0; i < K - 1; i++) r_f[i] <= r_f[i+1];
        r_f[K-1] <= w_s;
        case (r_state)
          S_FILL: begin
            r_c <= r_c + CW'(1);
            if (in_eol)                  r_state <= S_FLUSH;
            else if (r_c == CW'(K - 1))  r_state <= S_RUN;
          end
          S_RUN: begin
            if (in_eol) r_state <= S_FLUSH;
          end
          S_FLUSH: begin
            r_c <= r_c - CW'(1);
            if (w_last) r_state <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sol   = r_out_sol;
  assign out_eol   = r_out_eol;
  assign sync_err  = r_sync_err;
  assign busy      = (r_state != S_IDLE) || r_out_valid;

endmodule
